// File: rtl/streamlined_multiplier_4bit_booth.sv
// Sequential signed 4x4 radix-2 Booth multiplier, one recoding step per clock.
// start_sig/done_sig handshake; the 8-bit product holds until the next result.
module streamlined_multiplier_4bit_booth (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_sig,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic       busy_sig,
    output logic       done_sig,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  m_q, m_d;
    logic [4:0]  a_q, a_d;
    logic [3:0]  q_q, q_d;
    logic        q1_q, q1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  product_q, product_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  a_step;

    // 5-bit accumulator: a - m with m = -8 gives +8, which needs the extra bit
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   a_step = a_q + m_q;
            2'b10:   a_step = a_q - m_q;
            default: a_step = a_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                // First IDLE cycle after DONE closes out the operation; no accept here,
                // which keeps back-to-back accepts 8 edges apart.
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end else if (start_sig) begin
                    m_d     = {multiplicand[3], multiplicand};
                    a_d     = 5'd0;
                    q_d     = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = {a_step[4], a_step[4:1]};
                q_d   = {a_step[0], q_q[3:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = RESULT;
            end
            RESULT: begin
                product_d = {a_q[3:0], q_q};
                state_d   = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 5'd0;
            a_q       <= 5'd0;
            q_q       <= 4'd0;
            q1_q      <= 1'b0;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_sig = busy_q;
    assign done_sig = done_q;
    assign product  = product_q;

endmodule

// File: tb/tb_streamlined_multiplier_4bit_booth.sv
// Scoreboard bench for the Booth multiplier: stimulus pushes expected products,
// a negedge monitor pops and compares on every done_sig pulse.
module tb_streamlined_multiplier_4bit_booth;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_sig;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy_sig;
    logic       done_sig;
    logic [7:0] product;

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;

    streamlined_multiplier_4bit_booth dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_sig    (start_sig),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy_sig     (busy_sig),
        .done_sig     (done_sig),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done_sig === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got product %0h expected no pulse", product);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("product", {24'd0, product}, {24'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_sig && k < 20) begin
            tick();
            k++;
        end
        if (busy_sig) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation and check done_sig arrives 6 edges after accept
    task automatic do_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] e);
        int k;
        wait_idle();
        start_sig    = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_q.push_back(e);
        tick();
        start_sig = 1'b0;
        k = 0;
        while (!done_sig && k < 20) begin
            tick();
            k++;
        end
        chk("done_latency", k, 6);
        tick();
        chk("busy_after_done", {31'd0, busy_sig}, 32'd0);
    endtask

    initial begin
        int d0;
        rst_n        = 1'b0;
        start_sig    = 1'b0;
        multiplicand = 4'd0;
        multiplier   = 4'd0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy_sig}, 32'd0);
        chk("rst_done", {31'd0, done_sig}, 32'd0);
        chk("rst_product", {24'd0, product}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 3 x 5 with explicit per-edge timing
        start_sig = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
        exp_q.push_back(8'h0F);
        tick();                                   // E0
        start_sig = 1'b0;
        chk("busy_at_e0", {31'd0, busy_sig}, 32'd1);
        repeat (4) tick();                        // E0+4
        chk("product_pre_e5", {24'd0, product}, 32'd0);
        tick();                                   // E0+5
        chk("product_e5", {24'd0, product}, 32'h0F);
        chk("done_e5", {31'd0, done_sig}, 32'd0);
        tick();                                   // E0+6
        chk("done_e6", {31'd0, done_sig}, 32'd1);
        chk("busy_e6", {31'd0, busy_sig}, 32'd1);
        tick();                                   // E0+7
        chk("done_e7", {31'd0, done_sig}, 32'd0);
        chk("busy_e7", {31'd0, busy_sig}, 32'd0);

        // Accumulator-width corner cases and small directed values
        do_op(4'h8, 4'h8, 8'h40);                 // -8 x -8 = +64
        do_op(4'h8, 4'h7, 8'hC8);                 // -8 x 7 = -56
        do_op(4'h7, 4'hF, 8'hF9);                 // 7 x -1 = -7
        do_op(4'h0, 4'hB, 8'h00);                 // 0 x -5
        do_op(4'hF, 4'hF, 8'h01);                 // -1 x -1

        // Back-to-back with start held: operands changed at E0+2 are ignored
        wait_idle();
        start_sig = 1'b1; multiplicand = 4'd6; multiplier = 4'hE;
        exp_q.push_back(8'hF4);                   // 6 x -2 = -12
        exp_q.push_back(8'hF2);                   // -7 x 2 = -14
        d0 = done_cnt;
        tick();                                   // E0
        tick(); tick();                           // E0+2
        multiplicand = 4'h9; multiplier = 4'd2;
        repeat (4) tick();                        // E0+6
        chk("b2b_done_e6", {31'd0, done_sig}, 32'd1);
        tick();                                   // E0+7
        chk("b2b_busy_e7", {31'd0, busy_sig}, 32'd0);
        tick();                                   // E0+8: second accept
        chk("b2b_busy_e8", {31'd0, busy_sig}, 32'd1);
        chk("b2b_pulses", done_cnt - d0, 1);
        start_sig = 1'b0;
        wait_idle();
        tick();

        // Reset mid-CALC: everything clears, no pulse; then a normal op
        start_sig = 1'b1; multiplicand = 4'd5; multiplier = 4'd5;
        d0 = done_cnt;
        tick();                                   // E0
        start_sig = 1'b0;
        repeat (3) tick();                        // E0+3
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_sig}, 32'd0);
        chk("abort_done", {31'd0, done_sig}, 32'd0);
        chk("abort_product", {24'd0, product}, 32'd0);
        tick();
        rst_n = 1'b1;
        do_op(4'd2, 4'd3, 8'h06);
        chk("abort_pulses", done_cnt - d0, 1);

        // start pulse while busy (E0+4) must be ignored
        wait_idle();
        start_sig = 1'b1; multiplicand = 4'd7; multiplier = 4'hF;
        exp_q.push_back(8'hF9);
        d0 = done_cnt;
        tick();                                   // E0
        start_sig = 1'b0;
        repeat (3) tick();
        start_sig = 1'b1; multiplicand = 4'd3; multiplier = 4'd3;
        tick();                                   // E0+4
        start_sig = 1'b0;
        repeat (14) tick();
        chk("ignore_pulses", done_cnt - d0, 1);
        chk("ignore_product", {24'd0, product}, 32'hF9);

        // Exhaustive sweep against a signed reference
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic signed [3:0] mi, qi;
                logic signed [7:0] pe;
                mi = 4'(i);
                qi = 4'(j);
                pe = mi * qi;
                do_op(mi, qi, pe);
            end
        end

        repeat (12) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
